mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter WORD_W, default `WORD_W (32), SHALL set the data width; only 32 is supported.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 op_valid  in  1  SHALL be high when the MEM stage presents a memory operation.
REQ-006 mem_op  in  `MEM_OP_W  SHALL be the decoded op: NOP, WR_BYTE/HALF/WORD, RD_BYTE/HALF/WORD, RD_BYTEU/HALFU.
REQ-007 addr  in  ADDR_W  SHALL be the byte address, i.e. the ALU result.
REQ-008 wdata  in  WORD_W  SHALL be the store data, aligned in bits [7:0]/[15:0]/[31:0].
REQ-009 op_ready  out  1  SHALL be high only in IDLE.
REQ-010 stall  out  1  SHALL be high while the pipeline must hold the MEM stage.
REQ-011 mreq, mwe  out  1 each  SHALL be the memory request and write-enable.
REQ-012 maddr  out  ADDR_W  SHALL be the word-aligned address {addr[ADDR_W-1:2],2'b00}.
REQ-013 mwdata  out  WORD_W; mbe  out  4  SHALL be the lane-replicated write data and byte enables.
REQ-014 mack  in  1; mrdata  in  WORD_W  SHALL be the memory acknowledge and read word.
REQ-015 rdata_valid  out  1; rdata  out  WORD_W  SHALL carry the extended load result.
REQ-016 misalign  out  1  SHALL exist only when MEM_SEQ_MISALIGN_TRAP_EN is defined.

Function
REQ-017 FSM states SHALL be IDLE, REQ and RESP.
REQ-018 In IDLE, op_valid with a non-NOP op SHALL latch op, addr and wdata, assert stall combinationally, and move to REQ.
REQ-019 NOP and any unlisted encoding SHALL complete in the same cycle: no memory cycle, stall low.
REQ-020 In REQ, mreq SHALL be high, and mwe, maddr, mwdata and mbe SHALL be registered and stable until the cycle mack is sampled high.
REQ-021 On mack in REQ, a store SHALL go to IDLE and a load SHALL go to RESP; stall SHALL be high throughout REQ.
REQ-022 In RESP, rdata_valid SHALL be high and stall low for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 mack SHALL be ignored outside REQ.
REQ-024 Minimum latency, acceptance at cycle T with mack at T+1: store stall high T..T+1; load rdata_valid at T+2.
REQ-025 Byte op: mbe = 1<<addr[1:0], mwdata = {4{wdata[7:0]}}.
REQ-026 Half op: mbe = 4'b0011<<(2*addr[1]), mwdata = {2{wdata[15:0]}}.
REQ-027 Word op: mbe = 4'b1111, mwdata = wdata.
REQ-028 Loads SHALL drive mbe = 4'b1111.
REQ-029 Load data SHALL select the byte/half from mrdata by the latched addr, sign-extend for RD_BYTE/RD_HALF and zero-extend for RD_BYTEU/RD_HALFU.
REQ-030 rdata SHALL be registered into RESP and held until the next load completes.

Reset
REQ-031 Reset SHALL force IDLE immediately: mreq=0, mwe=0, mbe=0, maddr=0, mwdata=0, rdata_valid=0, rdata=0, stall=0, misalign=0, op_ready=1.
REQ-032 Reset asserted in REQ or RESP SHALL abandon the access; a late mack after release SHALL be ignored.

Configuration
REQ-033 With MEM_SEQ_MISALIGN_TRAP_EN defined, a half op with addr[0]=1 or a word op with addr[1:0]!=0 SHALL issue no memory cycle, SHALL pulse misalign for one cycle at T+1, and SHALL hold stall only in cycle T.
REQ-034 Without the macro, misaligned ops SHALL issue normally, with half ops ignoring addr[0] and word ops ignoring addr[1:0]; the misalign port SHALL be absent.

Verification
REQ-035 WR_BYTE, addr=0x1003, wdata=0xAB, mack at T+1 -> maddr=0x1000, mbe=4'b1000, mwdata=0xABABABAB, mwe=1, stall high T..T+1.
REQ-036 RD_HALF, addr=0x2002, mrdata=0x80010000, mack delayed 3 cycles -> request stable for all 4 REQ cycles; rdata=0xFFFF8001 with rdata_valid one cycle later.
REQ-037 RD_BYTEU, addr=0x11, mrdata=0x0000F200 -> rdata=0x000000F2.
REQ-038 NOP with op_valid=1 for 5 cycles -> mreq never high, stall always 0.
REQ-039 rst_n low during REQ, then mack pulse after release -> mreq=0 immediately, FSM stays IDLE, no rdata_valid.
REQ-040 With MEM_SEQ_MISALIGN_TRAP_EN, WR_WORD at addr=0x6 -> misalign=1 at T+1, mreq never high; without the macro -> maddr=0x4, mbe=4'b1111.

Source files
------------

// File: rtl/mem_seq_if.sv
// ============================================================================
// mem_seq_if : MEM-stage op + memory bus bundle for mem_seq     Rev 1.0
// ============================================================================
`default_nettype none

`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif

interface mem_seq_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = `WORD_W
);
   logic                 op_valid;
   logic [`MEM_OP_W-1:0] mem_op;
   logic [ADDR_W-1:0]    addr;
   logic [WORD_W-1:0]    wdata;
   logic                 op_ready;
   logic                 stall;
   logic                 mreq;
   logic                 mwe;
   logic [ADDR_W-1:0]    maddr;
   logic [WORD_W-1:0]    mwdata;
   logic [3:0]           mbe;
   logic                 mack;
   logic [WORD_W-1:0]    mrdata;
   logic                 rdata_valid;
   logic [WORD_W-1:0]    rdata;

   // The sequencer masters the memory bus and serves the pipeline.
   modport master (
      input  op_valid, mem_op, addr, wdata, mack, mrdata,
      output op_ready, stall, mreq, mwe, maddr, mwdata, mbe, rdata_valid, rdata
   );

   modport slave (
      output op_valid, mem_op, addr, wdata, mack, mrdata,
      input  op_ready, stall, mreq, mwe, maddr, mwdata, mbe, rdata_valid, rdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_seq.sv
// ============================================================================
// mem_seq : IDLE/REQ/RESP load-store sequencer; MEM_SEQ_MISALIGN_TRAP_EN adds
//           a misaligned-access trap and the misalign port.          Rev 1.0
// ============================================================================
`default_nettype none

`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif

module mem_seq #(
   parameter int WORD_W = `WORD_W,
   parameter int ADDR_W = 32
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   mem_seq_if.master  bus
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
   ,
   output logic       misalign
`endif
);

   localparam logic [3:0] OP_WR_BYTE  = 4'd1;
   localparam logic [3:0] OP_WR_HALF  = 4'd2;
   localparam logic [3:0] OP_WR_WORD  = 4'd3;
   localparam logic [3:0] OP_RD_BYTE  = 4'd4;
   localparam logic [3:0] OP_RD_HALF  = 4'd5;
   localparam logic [3:0] OP_RD_WORD  = 4'd6;
   localparam logic [3:0] OP_RD_BYTEU = 4'd7;
   localparam logic [3:0] OP_RD_HALFU = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_op;
   logic [1:0]          r_lane;
   logic                r_mwe;
   logic [ADDR_W-1:0]   r_maddr;
   logic [WORD_W-1:0]   r_mwdata;
   logic [3:0]          r_mbe;
   logic [WORD_W-1:0]   r_rdata;

   logic                w_is_store;
   logic                w_is_load;
   logic                w_accept;
   logic                w_trap;
   logic                w_start;
   logic                w_r_is_load;
   logic [3:0]          w_mbe;
   logic [WORD_W-1:0]   w_mwdata;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [WORD_W-1:0]   w_ld;
   logic                w_stall;
   logic                w_ready;
   logic                w_mreq;
   logic                w_rvalid;

   assign w_is_store  = (bus.mem_op >= OP_WR_BYTE) && (bus.mem_op <= OP_WR_WORD);
   assign w_is_load   = (bus.mem_op >= OP_RD_BYTE) && (bus.mem_op <= OP_RD_HALFU);
   // Gated by rst_n so stall stays low while reset is held.
   assign w_accept    = rst_n && (r_state == IDLE) && bus.op_valid && (w_is_store || w_is_load);
   assign w_start     = w_accept && !w_trap;
   assign w_r_is_load = (r_op >= OP_RD_BYTE);

`ifdef MEM_SEQ_MISALIGN_TRAP_EN
   logic w_half_op;
   logic w_word_op;
   logic r_misalign;

   assign w_half_op = (bus.mem_op == OP_WR_HALF) || (bus.mem_op == OP_RD_HALF) ||
                      (bus.mem_op == OP_RD_HALFU);
   assign w_word_op = (bus.mem_op == OP_WR_WORD) || (bus.mem_op == OP_RD_WORD);
   assign w_trap    = (w_half_op && bus.addr[0]) || (w_word_op && (bus.addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_accept && w_trap;
      end
   end

   assign misalign = r_misalign;
`else
   assign w_trap = 1'b0;
`endif

   // Store lane steering from the live op, captured on acceptance.
   always_comb begin
      w_mbe    = 4'b1111;
      w_mwdata = '0;
      case (bus.mem_op)
         OP_WR_BYTE: begin
            w_mbe    = 4'b0001 << bus.addr[1:0];
            w_mwdata = {4{bus.wdata[7:0]}};
         end
         OP_WR_HALF: begin
            w_mbe    = bus.addr[1] ? 4'b1100 : 4'b0011;
            w_mwdata = {2{bus.wdata[15:0]}};
         end
         OP_WR_WORD: begin
            w_mbe    = 4'b1111;
            w_mwdata = bus.wdata;
         end
         default: begin
            w_mbe    = 4'b1111;
            w_mwdata = '0;
         end
      endcase
   end

   always_comb begin
      w_byte = bus.mrdata[{r_lane, 3'b000} +: 8];
      w_half = r_lane[1] ? bus.mrdata[31:16] : bus.mrdata[15:0];
      w_ld   = bus.mrdata;
      case (r_op)
         OP_RD_BYTE:  w_ld = {{24{w_byte[7]}}, w_byte};
         OP_RD_BYTEU: w_ld = {24'h000000, w_byte};
         OP_RD_HALF:  w_ld = {{16{w_half[15]}}, w_half};
         OP_RD_HALFU: w_ld = {16'h0000, w_half};
         default:     w_ld = bus.mrdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_stall  = 1'b0;
      w_ready  = 1'b0;
      w_mreq   = 1'b0;
      w_rvalid = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            w_stall = w_accept;
            if (w_start) begin
               w_next = REQ;
            end
         end
         REQ: begin
            w_mreq  = 1'b1;
            w_stall = 1'b1;
            if (bus.mack) begin
               w_next = w_r_is_load ? RESP : IDLE;
            end
         end
         RESP: begin
            w_rvalid = 1'b1;
            w_next   = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= 4'd0;
         r_lane   <= 2'd0;
         r_mwe    <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
         r_mbe    <= 4'b0000;
         r_rdata  <= '0;
      end else begin
         if (w_start) begin
            r_op     <= bus.mem_op;
            r_lane   <= bus.addr[1:0];
            r_mwe    <= w_is_store;
            r_maddr  <= {bus.addr[ADDR_W-1:2], 2'b00};
            r_mwdata <= w_mwdata;
            r_mbe    <= w_mbe;
         end
         if ((r_state == REQ) && bus.mack && w_r_is_load) begin
            r_rdata <= w_ld;
         end
      end
   end

   assign bus.op_ready    = w_ready;
   assign bus.stall       = w_stall;
   assign bus.mreq        = w_mreq;
   assign bus.mwe         = r_mwe;
   assign bus.maddr       = r_maddr;
   assign bus.mwdata      = r_mwdata;
   assign bus.mbe         = r_mbe;
   assign bus.rdata_valid = w_rvalid;
   assign bus.rdata       = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_seq.sv
// ============================================================================
// tb_mem_seq : vector-table bench for mem_seq (MEM_SEQ_MISALIGN_TRAP_EN aware)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_seq;

   localparam logic [3:0] NOP  = 4'd0;
   localparam logic [3:0] WRB  = 4'd1;
   localparam logic [3:0] WRH  = 4'd2;
   localparam logic [3:0] WRW  = 4'd3;
   localparam logic [3:0] RDB  = 4'd4;
   localparam logic [3:0] RDH  = 4'd5;
   localparam logic [3:0] RDW  = 4'd6;
   localparam logic [3:0] RDBU = 4'd7;
   localparam logic [3:0] RDHU = 4'd8;

   // ctl bits: {stall, op_ready, mreq, mwe, rdata_valid}
   typedef struct {
      logic        ov;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mack;
      logic [31:0] mrdata;
      logic [4:0]  ectl;
      logic [3:0]  embe;
      logic [31:0] emaddr;
      logic [31:0] emwdata;
      logic [31:0] erdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_seq_if #(.ADDR_W(32), .WORD_W(32)) bus ();

`ifdef MEM_SEQ_MISALIGN_TRAP_EN
   logic misalign;
   mem_seq #(.WORD_W(32), .ADDR_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .misalign (misalign)
   );
`else
   mem_seq #(.WORD_W(32), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ov, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic mack, input logic [31:0] mrdata,
                               input logic [4:0] ectl, input logic [3:0] embe, input logic [31:0] emaddr,
                               input logic [31:0] emwdata, input logic [31:0] erdata);
      vec_t v;
      v.ov = ov; v.op = op; v.addr = addr; v.wdata = wdata; v.mack = mack; v.mrdata = mrdata;
      v.ectl = ectl; v.embe = embe; v.emaddr = emaddr; v.emwdata = emwdata; v.erdata = erdata;
      return v;
   endfunction

   function automatic logic [4:0] ctl();
      return {bus.stall, bus.op_ready, bus.mreq, bus.mwe, bus.rdata_valid};
   endfunction

   task automatic drive(input logic ov, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic mack, input logic [31:0] mrdata);
      bus.op_valid = ov;
      bus.mem_op   = op;
      bus.addr     = addr;
      bus.wdata    = wdata;
      bus.mack     = mack;
      bus.mrdata   = mrdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t vt[31];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b01000, 4'b0000, 32'h0,    32'h0,        32'h0);
      vt[1]  = mk(1, WRB,  32'h1003, 32'h000000AB, 0, 32'h0,        5'b11000, 4'b0000, 32'h0,    32'h0,        32'h0);
      vt[2]  = mk(0, NOP,  32'h0,    32'h0,        1, 32'h0,        5'b10110, 4'b1000, 32'h1000, 32'hABABABAB, 32'h0);
      vt[3]  = mk(0, NOP,  32'h0,    32'h0,        1, 32'h0,        5'b01010, 4'b1000, 32'h1000, 32'hABABABAB, 32'h0);
      vt[4]  = mk(1, RDH,  32'h2002, 32'h12345678, 0, 32'h0,        5'b11010, 4'b1000, 32'h1000, 32'hABABABAB, 32'h0);
      vt[5]  = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b10100, 4'b1111, 32'h2000, 32'h0,        32'h0);
      vt[6]  = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b10100, 4'b1111, 32'h2000, 32'h0,        32'h0);
      vt[7]  = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b10100, 4'b1111, 32'h2000, 32'h0,        32'h0);
      vt[8]  = mk(0, NOP,  32'h0,    32'h0,        1, 32'h80010000, 5'b10100, 4'b1111, 32'h2000, 32'h0,        32'h0);
      vt[9]  = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b00001, 4'b1111, 32'h2000, 32'h0,        32'hFFFF8001);
      vt[10] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b01000, 4'b1111, 32'h2000, 32'h0,        32'hFFFF8001);
      vt[11] = mk(1, RDBU, 32'h11,   32'h0,        0, 32'h0,        5'b11000, 4'b1111, 32'h2000, 32'h0,        32'hFFFF8001);
      vt[12] = mk(0, NOP,  32'h0,    32'h0,        1, 32'h0000F200, 5'b10100, 4'b1111, 32'h10,   32'h0,        32'hFFFF8001);
      vt[13] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b00001, 4'b1111, 32'h10,   32'h0,        32'h000000F2);
      vt[14] = mk(1, RDB,  32'h13,   32'h0,        0, 32'h0,        5'b11000, 4'b1111, 32'h10,   32'h0,        32'h000000F2);
      vt[15] = mk(0, NOP,  32'h0,    32'h0,        1, 32'h85000000, 5'b10100, 4'b1111, 32'h10,   32'h0,        32'h000000F2);
      vt[16] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b00001, 4'b1111, 32'h10,   32'h0,        32'hFFFFFF85);
      vt[17] = mk(1, WRH,  32'h22,   32'h1234CDEF, 0, 32'h0,        5'b11000, 4'b1111, 32'h10,   32'h0,        32'hFFFFFF85);
      vt[18] = mk(0, NOP,  32'h0,    32'h0,        1, 32'h0,        5'b10110, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[19] = mk(1, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b01010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[20] = mk(1, NOP,  32'h4,    32'h0,        0, 32'h0,        5'b01010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[21] = mk(1, NOP,  32'h8,    32'h0,        1, 32'h0,        5'b01010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[22] = mk(1, NOP,  32'hC,    32'h0,        0, 32'h0,        5'b01010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[23] = mk(1, 4'hF, 32'h10,   32'h0,        0, 32'h0,        5'b01010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[24] = mk(1, RDHU, 32'h40,   32'h0,        0, 32'h0,        5'b11010, 4'b1100, 32'h20,   32'hCDEFCDEF, 32'hFFFFFF85);
      vt[25] = mk(0, NOP,  32'h0,    32'h0,        1, 32'h1234ABCD, 5'b10100, 4'b1111, 32'h40,   32'h0,        32'hFFFFFF85);
      vt[26] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b00001, 4'b1111, 32'h40,   32'h0,        32'h0000ABCD);
      vt[27] = mk(1, RDW,  32'h44,   32'h0,        0, 32'h0,        5'b11000, 4'b1111, 32'h40,   32'h0,        32'h0000ABCD);
      vt[28] = mk(0, NOP,  32'h0,    32'h0,        1, 32'hDEADBEEF, 5'b10100, 4'b1111, 32'h44,   32'h0,        32'h0000ABCD);
      vt[29] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b00001, 4'b1111, 32'h44,   32'h0,        32'hDEADBEEF);
      vt[30] = mk(0, NOP,  32'h0,    32'h0,        0, 32'h0,        5'b01000, 4'b1111, 32'h44,   32'h0,        32'hDEADBEEF);

      rst_n = 1'b0;
      drive(0, NOP, 32'h0, 32'h0, 0, 32'h0);
      next_cycle();
      #2;
      chk("reset_ctl", {123'd0, ctl()}, {123'd0, 5'b01000});
      chk("reset_bus", {bus.mbe, bus.maddr, bus.mwdata, bus.rdata}, 128'd0);
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
      chk("reset_misalign", {127'd0, misalign}, 128'd0);
`endif
      next_cycle();
      rst_n = 1'b1;

      for (int i = 0; i < 31; i++) begin
         drive(vt[i].ov, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].mack, vt[i].mrdata);
         #2;
         chk($sformatf("vec%0d", i),
             {19'd0, ctl(), bus.mbe, bus.maddr, bus.mwdata, bus.rdata},
             {19'd0, vt[i].ectl, vt[i].embe, vt[i].emaddr, vt[i].emwdata, vt[i].erdata});
         next_cycle();
      end

      // Reset while a load sits in REQ, then a stale mack after release.
      drive(1, RDW, 32'h80, 32'h0, 0, 32'h0);
      #2;
      chk("rst_seq_accept_stall", {127'd0, bus.stall}, {127'd0, 1'b1});
      next_cycle();
      drive(0, NOP, 32'h0, 32'h0, 0, 32'h0);
      #2;
      chk("rst_seq_in_req", {127'd0, bus.mreq}, {127'd0, 1'b1});
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_seq_async_ctl", {123'd0, ctl()}, {123'd0, 5'b01000});
      chk("rst_seq_async_bus", {bus.mbe, bus.maddr, bus.mwdata, bus.rdata}, 128'd0);
      next_cycle();
      rst_n = 1'b1;
      drive(0, NOP, 32'h0, 32'h0, 1, 32'hFFFFFFFF);
      #2;
      chk("rst_seq_late_mack0", {123'd0, ctl()}, {123'd0, 5'b01000});
      next_cycle();
      #2;
      chk("rst_seq_late_mack1", {123'd0, ctl()}, {123'd0, 5'b01000});
      bus.mack = 1'b0;
      next_cycle();
      #2;
      chk("rst_seq_after", {91'd0, ctl(), bus.rdata}, {91'd0, 5'b01000, 32'h0});
      next_cycle();

      // Misaligned word store at 0x6.
      drive(1, WRW, 32'h6, 32'h13579BDF, 0, 32'h0);
      #2;
      chk("mis_accept", {126'd0, bus.stall, bus.mreq}, {126'd0, 2'b10});
      next_cycle();
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
      drive(0, NOP, 32'h0, 32'h0, 1, 32'h0);
      #2;
      chk("mis_trap_t1", {125'd0, misalign, bus.mreq, bus.stall}, {125'd0, 3'b100});
      next_cycle();
      #2;
      chk("mis_trap_t2", {125'd0, misalign, bus.mreq, bus.stall}, {125'd0, 3'b000});
      bus.mack = 1'b0;
      next_cycle();
`else
      drive(0, NOP, 32'h0, 32'h0, 1, 32'h0);
      #2;
      chk("mis_issue_req", {54'd0, ctl(), bus.mbe, bus.maddr, bus.mwdata},
          {54'd0, 5'b10110, 4'b1111, 32'h4, 32'h13579BDF});
      next_cycle();
      bus.mack = 1'b0;
      #2;
      chk("mis_issue_done", {123'd0, ctl()}, {123'd0, 5'b01010});
      next_cycle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
